dbg_mailbox_ctrl: RTL and testbench

- Controller for the memory-mapped debug argument RAM: eight 32-bit words, where word 0 is the function code and words 1..7 are arguments.
- Captures core writes into the RAM. A write to word 0 freezes all eight words into a snapshot and starts one host transaction.
- Function 3 (print) is handled inside the block: it streams up to four ASCII bytes over a byte handshake. All other functions are presented to the host as a command handshake.
- The core stalls on any debug write while a transaction is outstanding. This keeps command ordering strict and removes the need for polling delays.

---
 rtl/dbg_mailbox_ctrl_if.sv | 37 +++
 rtl/dbg_mailbox_ctrl.sv | 107 ++++++++++
 tb/tb_dbg_mailbox_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_mailbox_ctrl_if.sv
// Bundle of the core write port, host command port and print byte port of the
// debug mailbox controller, plus the controller's state for observation.
interface dbg_mailbox_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_stall;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_func;
    logic [ADDR_W-1:0] arg_sel;
    logic [DATA_W-1:0] arg_data;
    logic              char_valid;
    logic              char_ready;
    logic [7:0]        char_data;
    logic              finished;
    logic [CNT_W-1:0]  cmd_count;
    logic [1:0]        dbg_state;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never drops before that edge, ready while valid=0 is ignored.
    modport slave (
        input  dbg_we, dbg_addr, dbg_wdata, cmd_ready, arg_sel, char_ready,
        output dbg_stall, cmd_valid, cmd_func, arg_data, char_valid, char_data,
               finished, cmd_count, dbg_state
    );

    modport master (
        output dbg_we, dbg_addr, dbg_wdata, cmd_ready, arg_sel, char_ready,
        input  dbg_stall, cmd_valid, cmd_func, arg_data, char_valid, char_data,
               finished, cmd_count, dbg_state
    );
endinterface

// File: rtl/dbg_mailbox_ctrl.sv
// Debug argument RAM controller: captures core writes, snapshots on a function
// write, and runs one host command or an internal print per snapshot.
module dbg_mailbox_ctrl #(
    parameter int DATA_W = 32,
    parameter int ARG_N  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    dbg_mailbox_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_CHAR = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] live [ARG_N];
    logic [DATA_W-1:0] snap [ARG_N];
    logic [1:0]        char_idx;
    logic [CNT_W-1:0]  cmd_count;
    logic              finished;

    logic              accept;
    logic              start;
    logic [7:0]        char_byte;
    logic              cmd_hs;
    logic              char_hs;
    logic              char_done;

    assign accept    = bus.dbg_we && (state == S_IDLE);
    assign start     = accept && (bus.dbg_addr == '0);
    // Byte lane selected by char_idx; forced to zero outside a print.
    assign char_byte = (state == S_CHAR) ? snap[1][{char_idx, 3'b000} +: 8] : 8'h00;
    assign cmd_hs    = (state == S_CMD) && bus.cmd_ready;
    assign char_hs   = (state == S_CHAR) && (char_byte != 8'h00) && bus.char_ready;
    // A zero byte terminates the string early without being emitted.
    assign char_done = (state == S_CHAR) &&
                       ((char_byte == 8'h00) || (char_hs && (char_idx == 2'd3)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARG_N; i++) begin
                live[i] <= '0;
                snap[i] <= '0;
            end
        end else if (accept) begin
            live[bus.dbg_addr] <= bus.dbg_wdata;
            if (start) begin
                for (int i = 0; i < ARG_N; i++) begin
                    snap[i] <= live[i];
                end
                snap[0] <= bus.dbg_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            char_idx  <= 2'd0;
            cmd_count <= '0;
            finished  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= (bus.dbg_wdata == DATA_W'(3)) ? S_CHAR : S_CMD;
                        char_idx <= 2'd0;
                    end
                end
                S_CMD: begin
                    if (cmd_hs) begin
                        cmd_count <= cmd_count + CNT_W'(1);
                        if (snap[0] == '0) begin
                            state    <= S_HALT;
                            finished <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_CHAR: begin
                    if (char_done) begin
                        state     <= S_IDLE;
                        cmd_count <= cmd_count + CNT_W'(1);
                    end else if (char_hs) begin
                        char_idx <= char_idx + 2'd1;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dbg_stall  = bus.dbg_we && (state != S_IDLE);
    assign bus.cmd_valid  = (state == S_CMD);
    assign bus.cmd_func   = snap[0];
    assign bus.arg_data   = snap[bus.arg_sel];
    assign bus.char_valid = (char_byte != 8'h00);
    assign bus.char_data  = char_byte;
    assign bus.finished   = finished;
    assign bus.cmd_count  = cmd_count;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_dbg_mailbox_ctrl.sv
// Directed bench for dbg_mailbox_ctrl: command, stall, print, finish and
// mid-print reset scenarios with hand-computed expectations.
module tb_dbg_mailbox_ctrl;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_CHAR = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    dbg_mailbox_ctrl_if #(.DATA_W(32), .ADDR_W(3), .CNT_W(16)) mb ();

    dbg_mailbox_ctrl #(.DATA_W(32), .ARG_N(8), .ADDR_W(3), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mb.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Driver: holds the write until the controller stops stalling, then
    // releases it just after the accepting edge.
    task automatic core_write(input logic [2:0] a, input logic [31:0] d);
        int n;
        n = 0;
        mb.dbg_we    = 1'b1;
        mb.dbg_addr  = a;
        mb.dbg_wdata = d;
        #1;
        while (mb.dbg_stall && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (n >= 50) begin
            n_err++;
            $display("FAIL write_timeout: stalled %0d cycles, required < 50", n);
        end
        @(posedge clk);
        #2;
        mb.dbg_we = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        mb.dbg_we     = 1'b0;
        mb.dbg_addr   = '0;
        mb.dbg_wdata  = '0;
        mb.cmd_ready  = 1'b0;
        mb.arg_sel    = '0;
        mb.char_ready = 1'b0;
        #3;
        n_cmp++; if (mb.dbg_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", mb.dbg_stall); end
        n_cmp++; if (mb.cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_cmd_valid: got %b want 0", mb.cmd_valid); end
        n_cmp++; if (mb.char_valid !== 1'b0) begin n_err++; $display("FAIL rst_char_valid: got %b want 0", mb.char_valid); end
        n_cmp++; if (mb.finished !== 1'b0) begin n_err++; $display("FAIL rst_finished: got %b want 0", mb.finished); end
        n_cmp++; if (mb.cmd_func !== 32'h0) begin n_err++; $display("FAIL rst_cmd_func: got %h want 0", mb.cmd_func); end
        n_cmp++; if (mb.char_data !== 8'h0) begin n_err++; $display("FAIL rst_char_data: got %h want 0", mb.char_data); end
        n_cmp++; if (mb.cmd_count !== 16'h0) begin n_err++; $display("FAIL rst_count: got %0d want 0", mb.cmd_count); end
        n_cmp++; if (mb.dbg_state !== S_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", mb.dbg_state, S_IDLE); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_assert_cmd();
        core_write(3'd1, 32'h5);
        core_write(3'd2, 32'h5);
        n_cmp++; if (mb.cmd_valid !== 1'b0) begin n_err++; $display("FAIL cmd_pre_valid: got %b want 0", mb.cmd_valid); end
        core_write(3'd0, 32'h1);
        mb.arg_sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (mb.cmd_valid !== 1'b1) begin n_err++; $display("FAIL cmd_valid[%0d]: got %b want 1", i, mb.cmd_valid); end
            n_cmp++; if (mb.cmd_func !== 32'h1) begin n_err++; $display("FAIL cmd_func[%0d]: got %h want 1", i, mb.cmd_func); end
            n_cmp++; if (mb.arg_data !== 32'h5) begin n_err++; $display("FAIL cmd_arg2[%0d]: got %h want 5", i, mb.arg_data); end
            step();
        end
        mb.cmd_ready = 1'b1;
        step();
        mb.cmd_ready = 1'b0;
        n_cmp++; if (mb.dbg_state !== S_IDLE) begin n_err++; $display("FAIL cmd_done_state: got %0d want %0d", mb.dbg_state, S_IDLE); end
        n_cmp++; if (mb.cmd_valid !== 1'b0) begin n_err++; $display("FAIL cmd_done_valid: got %b want 0", mb.cmd_valid); end
        n_cmp++; if (mb.cmd_count !== 16'd1) begin n_err++; $display("FAIL cmd_count: got %0d want 1", mb.cmd_count); end
    endtask

    task automatic test_stall();
        core_write(3'd0, 32'h7);
        mb.dbg_we    = 1'b1;
        mb.dbg_addr  = 3'd1;
        mb.dbg_wdata = 32'hAA;
        mb.arg_sel   = 3'd1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (mb.dbg_stall !== 1'b1) begin n_err++; $display("FAIL stall_pending[%0d]: got %b want 1", i, mb.dbg_stall); end
            step();
        end
        mb.cmd_ready = 1'b1;
        #1;
        n_cmp++; if (mb.dbg_stall !== 1'b1) begin n_err++; $display("FAIL stall_hs_cycle: got %b want 1", mb.dbg_stall); end
        step();
        mb.cmd_ready = 1'b0;
        n_cmp++; if (mb.dbg_stall !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", mb.dbg_stall); end
        step();
        mb.dbg_we = 1'b0;
        #1;
        n_cmp++; if (mb.arg_data !== 32'h5) begin n_err++; $display("FAIL stall_snap_kept: got %h want 5", mb.arg_data); end
        n_cmp++; if (mb.dbg_state !== S_IDLE) begin n_err++; $display("FAIL stall_state: got %0d want %0d", mb.dbg_state, S_IDLE); end
        core_write(3'd0, 32'h5);
        n_cmp++; if (mb.cmd_func !== 32'h5) begin n_err++; $display("FAIL stall_func: got %h want 5", mb.cmd_func); end
        n_cmp++; if (mb.arg_data !== 32'hAA) begin n_err++; $display("FAIL stall_live1: got %h want aa", mb.arg_data); end
        mb.cmd_ready = 1'b1;
        step();
        mb.cmd_ready = 1'b0;
        n_cmp++; if (mb.cmd_count !== 16'd3) begin n_err++; $display("FAIL stall_count: got %0d want 3", mb.cmd_count); end
    endtask

    task automatic test_full_print();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h61; exp_b[1] = 8'h62; exp_b[2] = 8'h63; exp_b[3] = 8'h64;
        core_write(3'd1, 32'h64636261);
        mb.char_ready = 1'b1;
        core_write(3'd0, 32'h3);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mb.char_valid !== 1'b1) begin n_err++; $display("FAIL print_valid[%0d]: got %b want 1", i, mb.char_valid); end
            n_cmp++; if (mb.char_data !== exp_b[i]) begin n_err++; $display("FAIL print_byte[%0d]: got %h want %h", i, mb.char_data, exp_b[i]); end
            n_cmp++; if (mb.cmd_valid !== 1'b0) begin n_err++; $display("FAIL print_no_cmd[%0d]: got %b want 0", i, mb.cmd_valid); end
            step();
        end
        mb.char_ready = 1'b0;
        n_cmp++; if (mb.dbg_state !== S_IDLE) begin n_err++; $display("FAIL print_state: got %0d want %0d", mb.dbg_state, S_IDLE); end
        n_cmp++; if (mb.char_valid !== 1'b0) begin n_err++; $display("FAIL print_end_valid: got %b want 0", mb.char_valid); end
        n_cmp++; if (mb.cmd_count !== 16'd4) begin n_err++; $display("FAIL print_count: got %0d want 4", mb.cmd_count); end
    endtask

    task automatic test_short_print();
        logic [7:0] exp_d [4];
        logic       rdy   [4];
        exp_d[0] = 8'h48; exp_d[1] = 8'h48; exp_d[2] = 8'h49; exp_d[3] = 8'h49;
        rdy[0] = 1'b0; rdy[1] = 1'b1; rdy[2] = 1'b0; rdy[3] = 1'b1;
        core_write(3'd1, 32'h00004948);
        mb.char_ready = 1'b0;
        core_write(3'd0, 32'h3);
        for (int i = 0; i < 4; i++) begin
            mb.char_ready = rdy[i];
            n_cmp++; if (mb.char_valid !== 1'b1) begin n_err++; $display("FAIL short_valid[%0d]: got %b want 1", i, mb.char_valid); end
            n_cmp++; if (mb.char_data !== exp_d[i]) begin n_err++; $display("FAIL short_byte[%0d]: got %h want %h", i, mb.char_data, exp_d[i]); end
            step();
        end
        mb.char_ready = 1'b0;
        n_cmp++; if (mb.char_valid !== 1'b0) begin n_err++; $display("FAIL short_term_valid: got %b want 0", mb.char_valid); end
        n_cmp++; if (mb.dbg_state !== S_CHAR) begin n_err++; $display("FAIL short_term_state: got %0d want %0d", mb.dbg_state, S_CHAR); end
        step();
        n_cmp++; if (mb.dbg_state !== S_IDLE) begin n_err++; $display("FAIL short_state: got %0d want %0d", mb.dbg_state, S_IDLE); end
        n_cmp++; if (mb.cmd_count !== 16'd5) begin n_err++; $display("FAIL short_count: got %0d want 5", mb.cmd_count); end
    endtask

    task automatic test_empty_print();
        core_write(3'd1, 32'h0);
        mb.char_ready = 1'b1;
        core_write(3'd0, 32'h3);
        n_cmp++; if (mb.char_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid: got %b want 0", mb.char_valid); end
        step();
        mb.char_ready = 1'b0;
        n_cmp++; if (mb.dbg_state !== S_IDLE) begin n_err++; $display("FAIL empty_state: got %0d want %0d", mb.dbg_state, S_IDLE); end
        n_cmp++; if (mb.cmd_count !== 16'd6) begin n_err++; $display("FAIL empty_count: got %0d want 6", mb.cmd_count); end
    endtask

    task automatic test_finish();
        mb.cmd_ready = 1'b1;
        core_write(3'd0, 32'h0);
        n_cmp++; if (mb.cmd_valid !== 1'b1) begin n_err++; $display("FAIL fin_valid: got %b want 1", mb.cmd_valid); end
        n_cmp++; if (mb.finished !== 1'b0) begin n_err++; $display("FAIL fin_early: got %b want 0", mb.finished); end
        step();
        mb.cmd_ready = 1'b0;
        n_cmp++; if (mb.finished !== 1'b1) begin n_err++; $display("FAIL fin_flag: got %b want 1", mb.finished); end
        n_cmp++; if (mb.dbg_state !== S_HALT) begin n_err++; $display("FAIL fin_state: got %0d want %0d", mb.dbg_state, S_HALT); end
        n_cmp++; if (mb.cmd_count !== 16'd7) begin n_err++; $display("FAIL fin_count: got %0d want 7", mb.cmd_count); end
        mb.dbg_we   = 1'b1;
        mb.dbg_addr = 3'd2;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (mb.dbg_stall !== 1'b1) begin n_err++; $display("FAIL fin_stall[%0d]: got %b want 1", i, mb.dbg_stall); end
            step();
        end
        mb.dbg_we = 1'b0;
        #1;
        n_cmp++; if (mb.dbg_stall !== 1'b0) begin n_err++; $display("FAIL fin_no_we: got %b want 0", mb.dbg_stall); end
        n_cmp++; if (mb.finished !== 1'b1) begin n_err++; $display("FAIL fin_sticky: got %b want 1", mb.finished); end
    endtask

    task automatic test_mid_print_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        core_write(3'd1, 32'h44434241);
        mb.char_ready = 1'b1;
        core_write(3'd0, 32'h3);
        n_cmp++; if (mb.char_data !== 8'h41) begin n_err++; $display("FAIL mr_byte0: got %h want 41", mb.char_data); end
        step();
        n_cmp++; if (mb.char_data !== 8'h42) begin n_err++; $display("FAIL mr_byte1: got %h want 42", mb.char_data); end
        reset = 1'b0;
        #1;
        n_cmp++; if (mb.char_valid !== 1'b0) begin n_err++; $display("FAIL mr_async_valid: got %b want 0", mb.char_valid); end
        n_cmp++; if (mb.char_data !== 8'h0) begin n_err++; $display("FAIL mr_async_data: got %h want 0", mb.char_data); end
        n_cmp++; if (mb.cmd_count !== 16'h0) begin n_err++; $display("FAIL mr_async_count: got %0d want 0", mb.cmd_count); end
        mb.char_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        n_cmp++; if (mb.dbg_state !== S_IDLE) begin n_err++; $display("FAIL mr_state: got %0d want %0d", mb.dbg_state, S_IDLE); end
        n_cmp++; if (mb.finished !== 1'b0) begin n_err++; $display("FAIL mr_finished: got %b want 0", mb.finished); end
        core_write(3'd0, 32'h1);
        mb.arg_sel = 3'd1;
        #1;
        n_cmp++; if (mb.cmd_valid !== 1'b1) begin n_err++; $display("FAIL mr_cmd_valid: got %b want 1", mb.cmd_valid); end
        n_cmp++; if (mb.cmd_func !== 32'h1) begin n_err++; $display("FAIL mr_cmd_func: got %h want 1", mb.cmd_func); end
        n_cmp++; if (mb.arg_data !== 32'h0) begin n_err++; $display("FAIL mr_arg1_cleared: got %h want 0", mb.arg_data); end
        mb.cmd_ready = 1'b1;
        step();
        mb.cmd_ready = 1'b0;
        n_cmp++; if (mb.cmd_count !== 16'd1) begin n_err++; $display("FAIL mr_count: got %0d want 1", mb.cmd_count); end
        n_cmp++; if (mb.dbg_state !== S_IDLE) begin n_err++; $display("FAIL mr_end_state: got %0d want %0d", mb.dbg_state, S_IDLE); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_assert_cmd();
        test_stall();
        test_full_print();
        test_short_print();
        test_empty_print();
        test_finish();
        test_mid_print_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
